nanorv32_ahb_arb2: RTL and testbench

NANORV32_AHB_ARB2 -- requirements
Module: nanorv32_ahb_arb2

---
 rtl/nanorv32_ahb_arb2_if.sv | 15 +
 rtl/nanorv32_ahb_arb2.sv | 101 ++++++++++
 tb/tb_nanorv32_ahb_arb2.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/nanorv32_ahb_arb2_if.sv
// nanorv32_ahb_arb2_if: AHB-lite port bundle shared by the instruction, data and slave sides
interface nanorv32_ahb_arb2_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic              hresp;
  modport master (output haddr, htrans, hwrite, hsize, hwdata, input hrdata, hready, hresp);
  modport slave (input haddr, htrans, hwrite, hsize, hwdata, output hrdata, hready, hresp);
endinterface

// File: rtl/nanorv32_ahb_arb2.sv
// nanorv32_ahb_arb2: two-master (instruction/data) AHB-lite arbiter onto one shared slave
module nanorv32_ahb_arb2 #(
  parameter int ADDR_W = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic rst_n,
  nanorv32_ahb_arb2_if.slave ibus,
  nanorv32_ahb_arb2_if.slave dbus,
  nanorv32_ahb_arb2_if.master sbus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} own_t;
  own_t down, down_n;
  logic pi_v, pd_v, pd_w;
  logic [ADDR_W-1:0] pi_a, pd_a;
  logic [2:0] pi_s, pd_s;
  logic [SW-1:0] starve;
  logic [ADDR_W-1:0] h_a;
  logic [1:0] h_t;
  logic h_w;
  logic [2:0] h_s;
  logic live_i, live_d, src_i, src_d, win_i, issue_i, issue_d;
  logic [ADDR_W-1:0] a_n;
  logic [2:0] s_n;
  logic w_n;
  logic [1:0] t_n;
  // accepted live requests, winner selection and the fresh slave address phase
  always_comb begin
    live_i = rst_n && !pi_v && (down != OWN_I || sbus.hready) && ibus.htrans[1];
    live_d = rst_n && !pd_v && (down != OWN_D || sbus.hready) && dbus.htrans[1];
    src_i = pi_v || live_i;
    src_d = pd_v || live_d;
    win_i = src_i && (!src_d || starve == SW'(STARVE_MAX));
    issue_i = sbus.hready && win_i;
    issue_d = sbus.hready && src_d && !win_i;
    a_n = issue_i ? (pi_v ? pi_a : ibus.haddr) : issue_d ? (pd_v ? pd_a : dbus.haddr) : '0;
    s_n = issue_i ? (pi_v ? pi_s : ibus.hsize) : issue_d ? (pd_v ? pd_s : dbus.hsize) : 3'd0;
    w_n = issue_d && (pd_v ? pd_w : dbus.hwrite);
    t_n = (issue_i || issue_d) ? 2'b10 : 2'b00;
  end
  // data-phase owner register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) down <= OWN_NONE;
    else down <= down_n;
  end
  // owner follows the address-phase winner whenever the slave completes a beat
  always_comb begin
    down_n = sbus.hready ? (issue_i ? OWN_I : issue_d ? OWN_D : OWN_NONE) : down;
  end
  // master-side responses and slave address/data phase, held while the slave stalls
  always_comb begin
    ibus.hready = pi_v ? 1'b0 : (down == OWN_I ? sbus.hready : 1'b1);
    dbus.hready = pd_v ? 1'b0 : (down == OWN_D ? sbus.hready : 1'b1);
    ibus.hresp = down == OWN_I && sbus.hresp;
    dbus.hresp = down == OWN_D && sbus.hresp;
    ibus.hrdata = sbus.hrdata;
    dbus.hrdata = sbus.hrdata;
    sbus.hwdata = down == OWN_D ? dbus.hwdata : 32'h0;
    sbus.haddr = sbus.hready ? a_n : h_a;
    sbus.htrans = sbus.hready ? t_n : h_t;
    sbus.hwrite = sbus.hready ? w_n : h_w;
    sbus.hsize = sbus.hready ? s_n : h_s;
  end
  // pending buffers, starvation counter and the last presented address phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi_v <= 1'b0;
      pd_v <= 1'b0;
      pd_w <= 1'b0;
      pi_a <= '0;
      pd_a <= '0;
      pi_s <= '0;
      pd_s <= '0;
      starve <= '0;
      h_a <= '0;
      h_t <= 2'b00;
      h_w <= 1'b0;
      h_s <= '0;
    end else begin
      pi_v <= (pi_v || live_i) && !issue_i;
      pd_v <= (pd_v || live_d) && !issue_d;
      if (live_i) begin
        pi_a <= ibus.haddr;
        pi_s <= ibus.hsize;
      end
      if (live_d) begin
        pd_a <= dbus.haddr;
        pd_s <= dbus.hsize;
        pd_w <= dbus.hwrite;
      end
      starve <= (!src_i || issue_i) ? '0 : (issue_d && starve != SW'(STARVE_MAX)) ? starve + 1'b1 : starve;
      if (sbus.hready) begin
        h_a <= a_n;
        h_t <= t_n;
        h_w <= w_n;
        h_s <= s_n;
      end
    end
  end
endmodule

// File: tb/tb_nanorv32_ahb_arb2.sv
// tb_nanorv32_ahb_arb2: directed and random stimulus against a queue-based arbitration model
module tb_nanorv32_ahb_arb2;
  localparam int AW = 32;
  localparam int SM = 4;
  typedef struct packed {logic [AW-1:0] a; logic [2:0] s; logic w;} req_t;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int failures = 0;
  nanorv32_ahb_arb2_if #(.ADDR_W(AW)) ibus ();
  nanorv32_ahb_arb2_if #(.ADDR_W(AW)) dbus ();
  nanorv32_ahb_arb2_if #(.ADDR_W(AW)) sbus ();
  nanorv32_ahb_arb2 #(.ADDR_W(AW), .STARVE_MAX(SM)) dut (.clk(clk), .rst_n(rst_n), .ibus(ibus), .dbus(dbus), .sbus(sbus));
  always #5 clk = ~clk;
  req_t pq_i[$];
  req_t pq_d[$];
  req_t ci, cd, held, e_r;
  logic [1:0] held_t, e_t;
  int own, starve, who;
  logic e_rdy_i, e_rdy_d, acc_i, acc_d, hi, hd, e_ri, e_rd;
  logic [31:0] e_wd;
  task automatic ck(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic mreset();
    pq_i.delete();
    pq_d.delete();
    own = 0;
    starve = 0;
    held = '0;
    held_t = 2'b00;
  endtask
  task automatic chk();
    e_rdy_i = (pq_i.size() != 0) ? 1'b0 : (own == 1 ? sbus.hready : 1'b1);
    e_rdy_d = (pq_d.size() != 0) ? 1'b0 : (own == 2 ? sbus.hready : 1'b1);
    acc_i = rst_n && e_rdy_i && ibus.htrans[1];
    acc_d = rst_n && e_rdy_d && dbus.htrans[1];
    ci = (pq_i.size() != 0) ? pq_i[0] : {ibus.haddr, ibus.hsize, 1'b0};
    cd = (pq_d.size() != 0) ? pq_d[0] : {dbus.haddr, dbus.hsize, dbus.hwrite};
    hi = pq_i.size() != 0 || acc_i;
    hd = pq_d.size() != 0 || acc_d;
    who = !(sbus.hready && (hi || hd)) ? 0 : (hd && !(hi && starve == SM)) ? 2 : 1;
    e_t = sbus.hready ? (who != 0 ? 2'b10 : 2'b00) : held_t;
    e_r = !sbus.hready ? held : who == 1 ? ci : who == 2 ? cd : '0;
    e_wd = own == 2 ? dbus.hwdata : 32'h0;
    e_ri = own == 1 && sbus.hresp;
    e_rd = own == 2 && sbus.hresp;
    ck("htranss", sbus.htrans, e_t);
    ck("haddrs", sbus.haddr, e_r.a);
    ck("hsizes", sbus.hsize, e_r.s);
    ck("hwrites", sbus.hwrite, e_r.w);
    ck("hwdatas", sbus.hwdata, e_wd);
    ck("hreadyi", ibus.hready, e_rdy_i);
    ck("hreadyd", dbus.hready, e_rdy_d);
    ck("hrespi", ibus.hresp, e_ri);
    ck("hrespd", dbus.hresp, e_rd);
    ck("hrdatai", ibus.hrdata, sbus.hrdata);
    ck("hrdatad", dbus.hrdata, sbus.hrdata);
  endtask
  task automatic upd();
    bit pi, pd;
    if (!rst_n) return;
    pi = pq_i.size() != 0;
    pd = pq_d.size() != 0;
    if (pi) begin
      if (who == 1) void'(pq_i.pop_front());
    end else if (acc_i && who != 1) pq_i.push_back(ci);
    if (pd) begin
      if (who == 2) void'(pq_d.pop_front());
    end else if (acc_d && who != 2) pq_d.push_back(cd);
    if (!hi || who == 1) starve = 0;
    else if (who == 2 && starve < SM) starve++;
    if (sbus.hready) begin
      own = who;
      held = e_r;
      held_t = e_t;
    end
  endtask
  task automatic step(input logic [1:0] ti, input logic [31:0] ai, input logic [1:0] td, input logic [31:0] ad,
                      input logic wd, input logic [31:0] dat, input logic rs, input logic rsp);
    @(posedge clk);
    upd();
    @(negedge clk);
    ibus.htrans = ti;
    ibus.haddr = ai;
    ibus.hsize = 3'($urandom_range(0, 2));
    dbus.htrans = td;
    dbus.haddr = ad;
    dbus.hwrite = wd;
    dbus.hsize = 3'($urandom_range(0, 2));
    dbus.hwdata = dat;
    sbus.hready = rs;
    sbus.hresp = rsp;
    sbus.hrdata = $urandom;
    #4 chk();
  endtask
  initial begin
    rst_n = 1'b1;
    ibus.hwrite = 1'b0;
    ibus.hwdata = 32'h0;
    ibus.htrans = 2'b00;
    ibus.haddr = '0;
    ibus.hsize = 3'd0;
    dbus.htrans = 2'b00;
    dbus.haddr = '0;
    dbus.hsize = 3'd0;
    dbus.hwrite = 1'b0;
    dbus.hwdata = 32'h0;
    sbus.hready = 1'b1;
    sbus.hresp = 1'b0;
    sbus.hrdata = 32'h0;
    mreset();
    #1 rst_n = 1'b0;
    step(2'b10, 32'h80, 2'b10, 32'h90, 1'b0, 32'h0, 1'b1, 1'b1);
    ck("rst_htranss", sbus.htrans, 2'b00);
    ck("rst_hreadyi", ibus.hready, 1'b1);
    ck("rst_hrespd", dbus.hresp, 1'b0);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(2'b10, 32'h100, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("ifetch_addr", sbus.haddr, 32'h100);
    ck("ifetch_trans", sbus.htrans, 2'b10);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("ifetch_ready", ibus.hready, 1'b1);
    step(2'b10, 32'h104, 2'b10, 32'h2000, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("contend_first", sbus.haddr, 32'h2000);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("contend_hreadyi", ibus.hready, 1'b0);
    ck("contend_second", sbus.haddr, 32'h104);
    ck("contend_hreadyd", dbus.hready, 1'b1);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(2'b10, 32'h200, 2'b10, 32'h4000, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("starve_d0", sbus.haddr, 32'h4000);
    for (int k = 1; k < 4; k++) begin
      step(2'b00, 32'h0, 2'b10, 32'h4000 + 32'(4 * k), 1'b0, 32'h0, 1'b1, 1'b0);
      ck("starve_dk", sbus.haddr, 32'h4000 + 32'(4 * k));
    end
    step(2'b00, 32'h0, 2'b10, 32'h4010, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("starve_igrant", sbus.haddr, 32'h200);
    step(2'b00, 32'h0, 2'b10, 32'h4014, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("starve_dpend", sbus.haddr, 32'h4010);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(2'b00, 32'h0, 2'b10, 32'h3000, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    ck("wr_hwrites", sbus.hwrite, 1'b1);
    step(2'b10, 32'h300, 2'b00, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    ck("wait_hwdatas", sbus.hwdata, 32'hDEADBEEF);
    ck("wait_hold_addr", sbus.haddr, 32'h3000);
    ck("wait_hreadyi", ibus.hready, 1'b1);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    ck("wait_captured", ibus.hready, 1'b0);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);
    ck("wait_issue_i", sbus.haddr, 32'h300);
    ck("wait_last_wdata", sbus.hwdata, 32'hDEADBEEF);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("wait_done", ibus.hready, 1'b1);
    step(2'b00, 32'h0, 2'b10, 32'h5000, 1'b0, 32'h0, 1'b1, 1'b0);
    step(2'b10, 32'h500, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    ck("err1_hrespd", dbus.hresp, 1'b1);
    ck("err1_hrespi", ibus.hresp, 1'b0);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    ck("err2_hrespd", dbus.hresp, 1'b1);
    ck("err2_issue_i", sbus.haddr, 32'h500);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(2'b10, 32'h600, 2'b10, 32'h6000, 1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    upd();
    #2;
    sbus.hready = 1'b0;
    sbus.hresp = 1'b1;
    rst_n = 1'b0;
    mreset();
    #1;
    ck("arst_htranss", sbus.htrans, 2'b00);
    ck("arst_haddrs", sbus.haddr, 32'h0);
    ck("arst_hwrites", sbus.hwrite, 1'b0);
    ck("arst_hsizes", sbus.hsize, 3'd0);
    ck("arst_hreadyi", ibus.hready, 1'b1);
    ck("arst_hreadyd", dbus.hready, 1'b1);
    ck("arst_hrespi", ibus.hresp, 1'b0);
    ck("arst_hrespd", dbus.hresp, 1'b0);
    chk();
    step(2'b10, 32'h700, 2'b10, 32'h7000, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("arst_gated", sbus.htrans, 2'b00);
    step(2'b00, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(2'b00, 32'h0, 2'b10, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0);
    ck("post_rst_addr", sbus.haddr, 32'h10);
    ck("post_rst_trans", sbus.htrans, 2'b10);
    for (int n = 0; n < 400; n++)
      step(2'($urandom_range(0, 3)), $urandom, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
           $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
